// File: rtl/wb_write_queue.sv
// Writeback queue in front of the register-file write port: buffers (rd, data)
// results, drains one per cycle, and forwards the youngest queued value to readers.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_adr,
    input  logic [DW-1:0]              in_data,
    input  logic                       wr_hold,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_adr,
    output logic [DW-1:0]              rf_data,
    input  logic [AW-1:0]              rd_adr1,
    input  logic [AW-1:0]              rd_adr2,
    output logic                       fwd_hit1,
    output logic [DW-1:0]              fwd_data1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] mem_adr  [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          store;
    logic          pop;

    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid & in_ready;
    // Writes to r0 complete the handshake but are never queued.
    assign store    = push & (in_adr != '0);
    assign pop      = !empty & !wr_hold;

    assign rf_we   = pop;
    assign rf_adr  = mem_adr[rd_ptr];
    assign rf_data = mem_data[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({store, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_adr[wr_ptr]  <= in_adr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest) overrides earlier ones.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   r;
        logic [PW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < cnt) && (a != '0) && (mem_adr[idx] == a))
                r = {1'b1, mem_data[idx]};
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = lookup(rd_adr1);
        {fwd_hit2, fwd_data2} = lookup(rd_adr2);
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus randomized traffic checked
// against a queue-based model of the writeback FIFO.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_adr;
    logic [DW-1:0] in_data;
    logic          wr_hold;
    logic          rf_we;
    logic [AW-1:0] rf_adr;
    logic [DW-1:0] rf_data;
    logic [AW-1:0] rd_adr1;
    logic [AW-1:0] rd_adr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    wb_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_adr(in_adr), .in_data(in_data),
        .wr_hold(wr_hold),
        .rf_we(rf_we), .rf_adr(rf_adr), .rf_data(rf_data),
        .rd_adr1(rd_adr1), .rd_adr2(rd_adr2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_fwd(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (a != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].adr == a) begin
                    h = 1'b1;
                    d = mq[i].data;
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        logic          h;
        logic [DW-1:0] d;
        int            sz;
        sz = mq.size();
        chk("count", count, sz);
        chk("count_bound", count <= DEPTH, 1);
        chk("empty", empty, sz == 0);
        chk("full", full, sz == DEPTH);
        chk("in_ready", in_ready, sz < DEPTH);
        chk("rf_we", rf_we, (sz > 0) && !wr_hold);
        if (sz > 0) begin
            chk("rf_adr", rf_adr, mq[0].adr);
            chk("rf_data", rf_data, mq[0].data);
        end
        model_fwd(rd_adr1, h, d);
        chk("fwd_hit1", fwd_hit1, h);
        chk("fwd_data1", fwd_data1, d);
        model_fwd(rd_adr2, h, d);
        chk("fwd_hit2", fwd_hit2, h);
        chk("fwd_data2", fwd_data2, d);
    endtask

    // One clock cycle: drive, check before the edge, advance the model at the edge.
    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic h);
        logic do_push;
        logic do_pop;
        ent_t e;
        in_valid = v;
        in_adr   = a;
        in_data  = d;
        wr_hold  = h;
        #1;
        check_all();
        do_push = v && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && !h;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push && a != '0) begin
            e.adr  = a;
            e.data = d;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_adr = '0; in_data = '0; wr_hold = 1'b0;
        rd_adr1 = 5'd3; rd_adr2 = 5'd0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fwd_hit1", fwd_hit1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single write goes out the cycle after acceptance
        cyc(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        in_valid = 1'b0; #1;
        chk("t1_rf_we", rf_we, 1);
        chk("t1_rf_adr", rf_adr, 3);
        chk("t1_rf_data", rf_data, 32'hDEADBEEF);
        chk("t1_fwd_hit1", fwd_hit1, 1);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t1_empty_after", empty, 1);

        // fill under hold, stall on full, then drain in order
        for (int i = 1; i <= 4; i++) cyc(1'b1, AW'(i), 32'h100 + i, 1'b1);
        #1;
        chk("t2_full", full, 1);
        chk("t2_in_ready", in_ready, 0);
        cyc(1'b1, 5'd9, 32'h999, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b0; wr_hold = 1'b0; #1;
            chk("t2_drain_we", rf_we, 1);
            chk("t2_drain_adr", rf_adr, i);
            chk("t2_drain_data", rf_data, 32'h100 + i);
            cyc(1'b0, 5'd0, 32'h0, 1'b0);
        end
        #1;
        chk("t2_empty", empty, 1);

        // youngest match forwarding
        rd_adr1 = 5'd5;
        cyc(1'b1, 5'd5, 32'h11, 1'b1);
        cyc(1'b1, 5'd5, 32'h22, 1'b1);
        #1;
        chk("t3_hit", fwd_hit1, 1);
        chk("t3_data", fwd_data1, 32'h22);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        #1;
        chk("t3_hit_drained", fwd_hit1, 0);
        chk("t3_data_drained", fwd_data1, 0);

        // r0 writes are accepted and dropped
        rd_adr2 = 5'd0;
        in_valid = 1'b1; in_adr = 5'd0; in_data = 32'h55; #1;
        chk("t4_in_ready", in_ready, 1);
        cyc(1'b1, 5'd0, 32'h55, 1'b0);
        #1;
        chk("t4_count", count, 0);
        chk("t4_rf_we", rf_we, 0);
        chk("t4_fwd_hit2", fwd_hit2, 0);

        // push every cycle with toggling hold, wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            rd_adr1 = AW'($urandom_range(0, 7));
            rd_adr2 = 5'd0;
            cyc(1'b1, AW'($urandom_range(1, 7)), $urandom, (i % 2) == 0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rd_adr1 = AW'($urandom_range(0, 7));
            rd_adr2 = AW'($urandom_range(0, 7));
            cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0);
        end

        // async reset with entries queued
        for (int i = 0; i < 8 && mq.size() > 0; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0);
        for (int i = 1; i <= 3; i++) cyc(1'b1, AW'(i + 10), 32'hA0 + i, 1'b1);
        #1;
        chk("t6_pre_count", count, 3);
        in_valid = 1'b0; wr_hold = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rf_we", rf_we, 0);
        chk("t6_rst_empty", empty, 1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_adr1 = 5'd11; rd_adr2 = 5'd12;
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b1, 5'd7, 32'h77, 1'b0);
        in_valid = 1'b0; #1;
        chk("t6_post_adr", rf_adr, 7);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
